// File: rtl/multiplier_ctrl.sv
// -----------------------------------------------------------------------------
// multiplier_ctrl
//
// Control FSM for a repeated-addition multiplier. The datapath holds A, B and
// the product P; this block sequences operand loading over a shared data bus,
// then adds A into P while decrementing B until the datapath reports B == 0.
//
// Build option:
//   MULT_CTRL_WATCHDOG_EN  - adds an 8-bit iteration counter that ends a run
//                            after 255 additions and raises err.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (beats every other input)
//   start     in   begin a multiplication (only seen in IDLE)
//   abort     in   cancel a run in LOAD_A / LOAD_B / ADD
//   op_valid  in   operand present on the datapath bus
//   eq        in   datapath flag: B register == 0
//   op_ready  out  operand can be taken (LOAD_A, LOAD_B)
//   ldA       out  load A from bus
//   ldB       out  load B from bus
//   clrP      out  clear product
//   ldP       out  P <= P + A
//   decB      out  B <= B - 1
//   busy      out  high outside IDLE
//   done      out  one-cycle completion pulse
//   err       out  watchdog expired (valid with done, held until next A load)
// -----------------------------------------------------------------------------
module multiplier_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic op_valid,
    input  logic eq,
    output logic op_ready,
    output logic ldA,
    output logic ldB,
    output logic clrP,
    output logic ldP,
    output logic decB,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StAdd,
        StDone
    } state_e;

    state_e state_q, state_d;

`ifdef MULT_CTRL_WATCHDOG_EN
    logic [7:0] iter_cnt_q, iter_cnt_d;
    logic       err_q, err_d;
    logic       wd_fire;
`endif

    always_comb begin
        state_d  = state_q;
        op_ready = 1'b0;
        ldA      = 1'b0;
        ldB      = 1'b0;
        clrP     = 1'b0;
        ldP      = 1'b0;
        decB     = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
`ifdef MULT_CTRL_WATCHDOG_EN
        wd_fire  = 1'b0;
        err      = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                op_ready = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (op_valid) begin
                    ldA     = 1'b1;
                    clrP    = 1'b1;
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                op_ready = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (op_valid) begin
                    ldB     = 1'b1;
                    state_d = StAdd;
                end
            end
            StAdd: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = StIdle;
                end else if (eq) begin
                    state_d = StDone;
`ifdef MULT_CTRL_WATCHDOG_EN
                end else if (iter_cnt_q == 8'd255) begin
                    // 255 additions already done and B still nonzero: give up.
                    wd_fire = 1'b1;
                    state_d = StDone;
`endif
                end else begin
                    ldP  = 1'b1;
                    decB = 1'b1;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs read 0 during the reset cycle itself, not just after it.
        if (reset) begin
            op_ready = 1'b0;
            ldA      = 1'b0;
            ldB      = 1'b0;
            clrP     = 1'b0;
            ldP      = 1'b0;
            decB     = 1'b0;
            busy     = 1'b0;
            done     = 1'b0;
            err      = 1'b0;
`ifdef MULT_CTRL_WATCHDOG_EN
            wd_fire  = 1'b0;
`endif
        end
    end

`ifdef MULT_CTRL_WATCHDOG_EN
    always_comb begin
        iter_cnt_d = iter_cnt_q;
        err_d      = err_q;
        if (ldB) begin
            iter_cnt_d = 8'd0;
        end else if (ldP) begin
            iter_cnt_d = iter_cnt_q + 8'd1;
        end
        if (ldA) begin
            err_d = 1'b0;
        end
        if (wd_fire) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iter_cnt_q <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            iter_cnt_q <= iter_cnt_d;
            err_q      <= err_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_multiplier_ctrl.sv
module tb_multiplier_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, abort, op_valid, eq;
    logic       op_ready, ldA, ldB, clrP, ldP, decB, busy, done, err;
    logic [7:0] data_in = 8'd0;
    logic [7:0] a_reg = 8'd0;
    logic [7:0] b_reg = 8'd0;
    logic [7:0] p_reg = 8'd0;
    logic       force_eq0 = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    multiplier_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .op_valid (op_valid),
        .eq       (eq),
        .op_ready (op_ready),
        .ldA      (ldA),
        .ldB      (ldB),
        .clrP     (clrP),
        .ldP      (ldP),
        .decB     (decB),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Datapath environment driven by the strobes.
    assign eq = force_eq0 ? 1'b0 : (b_reg == 8'd0);

    always @(posedge clk) begin
        if (ldA) a_reg <= data_in;
        if (ldB) b_reg <= data_in;
        else if (decB) b_reg <= b_reg - 8'd1;
        if (clrP) p_reg <= 8'd0;
        else if (ldP) p_reg <= p_reg + a_reg;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({op_ready, ldA, ldB, clrP, ldP, decB, busy, done, err});
    endfunction

    // One complete operation. exp_adds is the number of additions expected
    // (B normally, 255 when the watchdog ends the run).
    task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input int exp_adds,
                            input int ga, input int gb, input bit start_add,
                            input bit abort_done, input bit exp_err);
        int acc;
        int k;
        bit seen;
        start = 1'b1; abort = 1'b0; op_valid = 1'b0;
        #1;
        check_eq("idle_busy", 32'(busy), 32'd0);
        step();
        start = 1'b0;
        for (int i = 0; i < ga; i++) begin
            op_valid = 1'b0; data_in = 8'($urandom);
            #1;
            check_eq("loada_hold", 32'({op_ready, ldA, clrP, ldB}), 32'b1000);
            step();
        end
        op_valid = 1'b1; data_in = a;
        #1;
        check_eq("loada_accept", 32'({op_ready, ldA, clrP, busy}), 32'b1111);
        step();
        #0;
        check_eq("err_cleared", 32'(err), 32'd0);
        for (int i = 0; i < gb; i++) begin
            op_valid = 1'b0; data_in = 8'($urandom);
            #1;
            check_eq("loadb_hold", 32'({op_ready, ldB}), 32'b10);
            step();
        end
        op_valid = 1'b1; data_in = b;
        #1;
        check_eq("loadb_accept", 32'({op_ready, ldB, ldA}), 32'b110);
        acc = cyc;
        step();
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            k        = cyc - acc;
            start    = start_add;
            abort    = abort_done && (k == exp_adds + 2);
            op_valid = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom);
            #1;
            check_eq("add_strobes", 32'({ldA, ldB, clrP, ldP, decB, done}),
                     32'({1'b0, 1'b0, 1'b0, (k <= exp_adds), (k <= exp_adds),
                          (k == exp_adds + 2)}));
            if (done) seen = 1'b1;
            else step();
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("product", 32'(p_reg), 32'((int'(a) * exp_adds) % 256));
        check_eq("err_with_done", 32'(err), 32'(exp_err));
        step();
        start = 1'b0; abort = 1'b0; op_valid = 1'b0;
        #1;
        check_eq("back_idle", 32'({busy, done, err}), 32'({1'b0, 1'b0, exp_err}));
        step();
        check_eq("no_queued_start", 32'(busy), 32'd0);
    endtask

    // Drive to the second ADD cycle of A=4, B=6.
    task automatic to_second_add();
        start = 1'b1; abort = 1'b0; op_valid = 1'b0;
        step();
        start = 1'b0; op_valid = 1'b1; data_in = 8'd4;
        step();
        data_in = 8'd6;
        step();
        op_valid = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; abort = 1'b0; op_valid = 1'b1;
        step();
        check_eq("reset_outs", all_outs(), 32'd0);
        step();
        reset = 1'b0; start = 1'b0; op_valid = 1'b0;
        #1;
        check_eq("post_reset_outs", all_outs(), 32'd0);
        step();

        run_mult(8'd5, 8'd3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        run_mult(8'd7, 8'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_mult(8'd1, 8'd255, 255, 0, 0, 1'b0, 1'b0, 1'b0);
        run_mult(8'd9, 8'd4, 4, 3, 1, 1'b1, 1'b1, 1'b0);

        // Abort in the second ADD cycle.
        to_second_add();
        abort = 1'b1;
        #1;
        check_eq("abort_strobes", 32'({ldP, decB, busy}), 32'b001);
        step();
        abort = 1'b0;
        #1;
        check_eq("abort_idle", 32'({busy, done}), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("abort_no_done", 32'(done), 32'd0);
        end

        // Reset mid-ADD.
        to_second_add();
        reset = 1'b1; start = 1'b1; abort = 1'b0; op_valid = 1'b1;
        #1;
        check_eq("reset_midadd_outs", all_outs(), 32'd0);
        step();
        reset = 1'b0; start = 1'b0; op_valid = 1'b0;
        #1;
        check_eq("reset_after_outs", all_outs(), 32'd0);
        step();

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        #1;
        check_eq("start_abort_idle", 32'(busy), 32'd0);
        step();

        for (int t = 0; t < 20; t++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom_range(0, 40));
            run_mult(ra, rb, int'(rb), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef MULT_CTRL_WATCHDOG_EN
        force_eq0 = 1'b1;
        run_mult(8'd3, 8'd255, 255, 0, 0, 1'b0, 1'b0, 1'b1);
        force_eq0 = 1'b0;
        run_mult(8'd2, 8'd3, 3, 1, 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
